// File: rtl/agc_clk_pkg.sv
// AGC clock controller shared types: FSM state encoding, timepulse constants, index helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package agc_clk_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } agc_state_e;

    localparam int         MT_N    = 12;
    localparam logic [3:0] TP_NONE = 4'd0;

    // One-hot MT edge vector to timepulse number (1..12); TP_NONE if no bit set.
    function automatic logic [3:0] tp_encode(input logic [MT_N-1:0] onehot);
        logic [3:0] idx;
        idx = TP_NONE;
        for (int i = 0; i < MT_N; i++) begin
            if (onehot[i]) idx = 4'(i + 1);
        end
        return idx;
    endfunction

    // Timepulse expected after tp: 1..11 advance, 12 wraps to 1.
    function automatic logic [3:0] tp_next(input logic [3:0] tp);
        return (tp == 4'd12) ? 4'd1 : tp + 4'd1;
    endfunction

endpackage

// File: rtl/agc_mt_tracker.sv
// Watches MT01..MT12 rising edges: last timepulse index, sticky sequence fault, MCT counter.
// Latency: outputs registered, 1 SIM_CLK after the edge; o_mct_inc is combinational in the edge cycle.
// Backpressure: none; every cycle is sampled.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_mt             MT01..MT12 (bit0 = MT01), synchronous to i_clk
//   o_tp_index       last single-edge timepulse number, 0 = none since reset
//   o_mct_count      MT12 rising edges, wraps
//   o_mct_inc        MT12 rising edge this cycle (count increments at the coming edge)
//   o_mt_err         sticky fault: out-of-order edge or multiple edges in one cycle
module agc_mt_tracker
    import agc_clk_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [MT_N-1:0]  i_mt,
    output logic [3:0]       o_tp_index,
    output logic [CNT_W-1:0] o_mct_count,
    output logic             o_mct_inc,
    output logic             o_mt_err
);

    localparam logic [MT_N-1:0] MT_ONE = MT_N'(1);

    logic [MT_N-1:0]  r_mt_q;
    logic [3:0]       r_tp_index;
    logic [CNT_W-1:0] r_mct_count;
    logic             r_mt_err;

    logic [MT_N-1:0]  w_rise;
    logic             w_multi;
    logic             w_single;
    logic [3:0]       w_idx;
    logic             w_order_err;

    assign w_rise   = i_mt & ~r_mt_q;
    // Clearing the lowest set bit leaves something only when two or more edges coincide.
    assign w_multi  = ((w_rise & (w_rise - MT_ONE)) != '0);
    assign w_single = (w_rise != '0) && !w_multi;
    assign w_idx    = tp_encode(w_rise);
    // Before the first edge there is no reference, so any index is accepted.
    assign w_order_err = w_single && (r_tp_index != TP_NONE) && (w_idx != tp_next(r_tp_index));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mt_q      <= '0;
            r_tp_index  <= TP_NONE;
            r_mct_count <= '0;
            r_mt_err    <= 1'b0;
        end else begin
            r_mt_q <= i_mt;
            if (w_single) r_tp_index <= w_idx;
            if (w_multi || w_order_err) r_mt_err <= 1'b1;
            if (w_rise[MT_N-1]) r_mct_count <= r_mct_count + CNT_W'(1);
        end
    end

    assign o_tp_index  = r_tp_index;
    assign o_mct_count = r_mct_count;
    assign o_mct_inc   = w_rise[MT_N-1];
    assign o_mt_err    = r_mt_err;

endmodule

// File: rtl/agc_clock_ctl.sv
// AGC clock controller: divides SIM_CLK into a gated CLOCK with run / halt / N-MCT step modes.
// Latency: CLOCK and clk_en registered; first CLOCK rise one SIM_CLK after leaving HALT.
// Backpressure: none; requests are acted on at the next CLOCK period boundary.
// Ports:
//   SIM_CLK, SIM_RST        system clock, async active-low reset
//   run_req, halt_req       level requests (priority halt > step > run)
//   step_req, step_cnt      1-cycle pulse requesting step_cnt MCTs
//   MT                      MT01..MT12 from fpga_agc
//   CLOCK, clk_en           gated AGC clock and its rising-edge strobe
//   halted, tp_index, mct_count, mt_err   status
// Optional: define AGC_MCT_BREAK_EN to add brk_en / brk_mct MCT breakpoint inputs.
module agc_clock_ctl
    import agc_clk_pkg::*;
#(
    parameter int DIV    = 25,
    parameter int DIV_W  = 8,
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_cnt,
    input  logic [MT_N-1:0]   MT,
`ifdef AGC_MCT_BREAK_EN
    input  logic              brk_en,
    input  logic [CNT_W-1:0]  brk_mct,
`endif
    output logic              CLOCK,
    output logic              clk_en,
    output logic              halted,
    output logic [3:0]        tp_index,
    output logic [CNT_W-1:0]  mct_count,
    output logic              mt_err
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HI   = DIV_W'(DIV / 2);

    agc_state_e        r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_div_cnt, w_div_nxt;
    logic [STEP_W-1:0] r_remaining, w_rem_nxt;
    logic              r_step_pend;
    logic              r_clock;
    logic              r_clk_en;

    logic              w_bnd;
    logic              w_step_new;
    logic              w_step_go;
    logic              w_mct_inc;
    logic              w_brk_now;
    logic              w_run_ok;

    agc_mt_tracker #(
        .CNT_W (CNT_W)
    ) u_mt_tracker (
        .i_clk       (SIM_CLK),
        .i_rst_n     (SIM_RST),
        .i_mt        (MT),
        .o_tp_index  (tp_index),
        .o_mct_count (mct_count),
        .o_mct_inc   (w_mct_inc),
        .o_mt_err    (mt_err)
    );

    // Mode changes only at the end of a full period so CLOCK never gets a runt pulse.
    assign w_bnd      = (r_state == HALT) || (r_div_cnt == DIV_LAST);
    assign w_step_new = step_req && (step_cnt != '0);
    // step_req is a pulse; r_step_pend keeps it alive until the boundary.
    assign w_step_go  = w_step_new || r_step_pend;

`ifdef AGC_MCT_BREAK_EN
    logic r_brk_pend;
    logic r_brk_block;
    logic w_brk_hit;

    // Break fires in the cycle the counter is about to step onto brk_mct.
    assign w_brk_hit = brk_en && (r_state != HALT) && w_mct_inc
                       && ((mct_count + CNT_W'(1)) == brk_mct);
    assign w_brk_now = w_brk_hit || r_brk_pend;
    // After a break, a held run_req must drop before it can restart the clock.
    assign w_run_ok  = run_req && !r_brk_block;

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_brk_pend  <= 1'b0;
            r_brk_block <= 1'b0;
        end else begin
            r_brk_pend <= w_bnd ? 1'b0 : (r_brk_pend || w_brk_hit);
            if (!run_req) begin
                r_brk_block <= 1'b0;
            end else if (w_bnd && (r_state != HALT) && w_brk_now) begin
                r_brk_block <= 1'b1;
            end
        end
    end
`else
    assign w_brk_now = 1'b0;
    assign w_run_ok  = run_req;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (w_bnd) begin
            unique case (r_state)
                HALT: begin
                    if (halt_req)       w_state_nxt = HALT;
                    else if (w_step_go) w_state_nxt = STEP;
                    else if (w_run_ok)  w_state_nxt = RUN;
                end
                RUN: begin
                    if (halt_req || w_brk_now) w_state_nxt = HALT;
                    else if (w_step_go)        w_state_nxt = STEP;
                end
                STEP: begin
                    if (halt_req || w_brk_now)                    w_state_nxt = HALT;
                    else if (w_step_go)                           w_state_nxt = STEP;
                    else if (r_remaining == '0)                   w_state_nxt = HALT;
                end
                default: w_state_nxt = HALT;
            endcase
        end
    end

    always_comb begin
        w_rem_nxt = r_remaining;
        if (w_step_new) begin
            w_rem_nxt = step_cnt;
        end else if ((r_state == STEP) && w_mct_inc && (r_remaining != '0)) begin
            w_rem_nxt = r_remaining - 1'b1;
        end
        // Nothing carries over into HALT, so a later step starts clean.
        if (w_state_nxt == HALT) w_rem_nxt = '0;
    end

    always_comb begin
        w_div_nxt = r_div_cnt + 1'b1;
        if ((r_state == HALT) || (r_div_cnt == DIV_LAST)) w_div_nxt = '0;
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_state     <= HALT;
            r_div_cnt   <= '0;
            r_remaining <= '0;
            r_step_pend <= 1'b0;
            r_clock     <= 1'b0;
            r_clk_en    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div_cnt   <= w_div_nxt;
            r_remaining <= w_rem_nxt;
            r_step_pend <= w_bnd ? 1'b0 : (r_step_pend || w_step_new);
            // CLOCK is a flop output (glitch-free) tracking the next divider phase.
            r_clock     <= (w_state_nxt != HALT) && (w_div_nxt < DIV_HI);
            r_clk_en    <= (w_state_nxt != HALT) && (w_div_nxt == '0);
        end
    end

    assign CLOCK  = r_clock;
    assign clk_en = r_clk_en;
    assign halted = (r_state == HALT);

endmodule
